// File: rtl/id_stage_sb_if.sv
// IF/EX/WB-facing signal bundle of the scoreboarded decode stage.
// The stage itself takes the slave view; its neighbours drive the master view.
interface id_stage_sb_if #(
    parameter int XLEN = 64
);
    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] in_pc;
    logic [31:0]     in_instr;

    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_pc;
    logic [31:0]     out_instr;
    logic [XLEN-1:0] out_rs1_data;
    logic [XLEN-1:0] out_rs2_data;
    logic [XLEN-1:0] out_imm;
    logic [4:0]      out_rd_idx;
    logic            out_wben;

    logic            wb_done;
    logic            wb_wren;
    logic [4:0]      wb_rd_idx;
    logic [XLEN-1:0] wb_data;

    logic            flush;

    modport master (
        output in_valid, in_pc, in_instr, out_ready,
        output wb_done, wb_wren, wb_rd_idx, wb_data, flush,
        input  in_ready, out_valid, out_pc, out_instr,
        input  out_rs1_data, out_rs2_data, out_imm, out_rd_idx, out_wben
    );

    modport slave (
        input  in_valid, in_pc, in_instr, out_ready,
        input  wb_done, wb_wren, wb_rd_idx, wb_data, flush,
        output in_ready, out_valid, out_pc, out_instr,
        output out_rs1_data, out_rs2_data, out_imm, out_rd_idx, out_wben
    );
endinterface

// File: rtl/id_stage_sb.sv
// RV64I decode stage with register file, per-register writer scoreboard and registered output slice.
// Optional macro ID_SB_WB_BYPASS_EN forwards same-cycle writeback data and lets that retirement clear a hazard.
module id_stage_sb #(
    parameter int              XLEN     = 64,
    parameter int              SB_CNT_W = 2,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input logic          clk,
    input logic          rst,
    id_stage_sb_if.slave bus
);
    localparam int EFF_W = SB_CNT_W + 1;
    localparam logic [SB_CNT_W-1:0] SB_MAX = '1;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_IMM32  = 7'b0011011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_REG32  = 7'b0111011;

    logic [6:0]      w_opcode;
    logic [4:0]      w_rs1Idx;
    logic [4:0]      w_rs2Idx;
    logic [4:0]      w_rdIdx;
    logic            w_usesRs1;
    logic            w_usesRs2;
    logic            w_writesRd;
    logic [XLEN-1:0] w_imm;

    logic                r_outValid;
    logic [XLEN-1:0]     r_outPc;
    logic [31:0]         r_outInstr;
    logic [XLEN-1:0]     r_outRs1;
    logic [XLEN-1:0]     r_outRs2;
    logic [XLEN-1:0]     r_outImm;
    logic [4:0]          r_outRdIdx;
    logic                r_outWben;
    logic [XLEN-1:0]     r_regFile [32];
    logic [SB_CNT_W-1:0] r_sb [32];

    logic [SB_CNT_W-1:0] w_sbNext [32];
    logic [EFF_W-1:0]    w_eff [32];
    logic [31:0]         w_inc;
    logic [31:0]         w_dec;
    logic                w_issue;
    logic                w_hazard;
    logic                w_inReady;
    logic                w_accept;
    logic                w_wbWrite;
    logic [XLEN-1:0]     w_rs1Data;
    logic [XLEN-1:0]     w_rs2Data;

    assign w_opcode = bus.in_instr[6:0];
    assign w_rdIdx  = bus.in_instr[11:7];
    assign w_rs1Idx = bus.in_instr[19:15];
    assign w_rs2Idx = bus.in_instr[24:20];

    always_comb begin
        w_usesRs1  = 1'b0;
        w_usesRs2  = 1'b0;
        w_writesRd = 1'b0;
        w_imm      = '0;
        case (w_opcode)
            OP_LUI, OP_AUIPC: begin
                w_writesRd = 1'b1;
                w_imm      = {{(XLEN-32){bus.in_instr[31]}}, bus.in_instr[31:12], 12'b0};
            end
            OP_JAL: begin
                w_writesRd = 1'b1;
                w_imm      = {{(XLEN-21){bus.in_instr[31]}}, bus.in_instr[31], bus.in_instr[19:12],
                              bus.in_instr[20], bus.in_instr[30:21], 1'b0};
            end
            OP_JALR, OP_LOAD, OP_IMM, OP_IMM32: begin
                w_usesRs1  = 1'b1;
                w_writesRd = 1'b1;
                w_imm      = {{(XLEN-12){bus.in_instr[31]}}, bus.in_instr[31:20]};
            end
            OP_BRANCH: begin
                w_usesRs1 = 1'b1;
                w_usesRs2 = 1'b1;
                w_imm     = {{(XLEN-13){bus.in_instr[31]}}, bus.in_instr[31], bus.in_instr[7],
                             bus.in_instr[30:25], bus.in_instr[11:8], 1'b0};
            end
            OP_STORE: begin
                w_usesRs1 = 1'b1;
                w_usesRs2 = 1'b1;
                w_imm     = {{(XLEN-12){bus.in_instr[31]}}, bus.in_instr[31:25], bus.in_instr[11:7]};
            end
            OP_REG, OP_REG32: begin
                w_usesRs1  = 1'b1;
                w_usesRs2  = 1'b1;
                w_writesRd = 1'b1;
            end
            default: begin
                w_usesRs1 = 1'b0;
            end
        endcase
    end

    assign w_issue   = r_outValid & bus.out_ready;
    assign w_wbWrite = bus.wb_done & bus.wb_wren & (bus.wb_rd_idx != 5'd0);

    // An issue and a retirement on the same register cancel; a retirement on an idle counter is dropped.
    always_comb begin
        w_inc = '0;
        w_dec = '0;
        for (int i = 0; i < 32; i++) begin
            w_inc[i]    = w_issue & r_outWben & (r_outRdIdx == 5'(i));
            w_dec[i]    = bus.wb_done & (bus.wb_rd_idx == 5'(i));
            w_sbNext[i] = r_sb[i];
            if (w_inc[i] && !w_dec[i]) begin
                w_sbNext[i] = r_sb[i] + 1'b1;
            end else if (w_dec[i] && !w_inc[i] && (r_sb[i] != '0)) begin
                w_sbNext[i] = r_sb[i] - 1'b1;
            end
`ifdef ID_SB_WB_BYPASS_EN
            w_eff[i] = {1'b0, w_sbNext[i]};
`else
            w_eff[i] = {1'b0, r_sb[i]} + EFF_W'(w_inc[i]);
`endif
        end
    end

    assign w_hazard  = (w_usesRs1 & (w_rs1Idx != 5'd0) & (w_eff[w_rs1Idx] != '0))
                     | (w_usesRs2 & (w_rs2Idx != 5'd0) & (w_eff[w_rs2Idx] != '0))
                     | (w_writesRd & (w_rdIdx != 5'd0) & (w_eff[w_rdIdx] == {1'b0, SB_MAX}));
    assign w_inReady = ~bus.flush & (~r_outValid | bus.out_ready) & ~w_hazard;
    assign w_accept  = bus.in_valid & w_inReady;

    always_comb begin
        w_rs1Data = '0;
        w_rs2Data = '0;
        if (w_usesRs1 && (w_rs1Idx != 5'd0)) begin
            w_rs1Data = r_regFile[w_rs1Idx];
`ifdef ID_SB_WB_BYPASS_EN
            if (w_wbWrite && (bus.wb_rd_idx == w_rs1Idx)) begin
                w_rs1Data = bus.wb_data;
            end
`endif
        end
        if (w_usesRs2 && (w_rs2Idx != 5'd0)) begin
            w_rs2Data = r_regFile[w_rs2Idx];
`ifdef ID_SB_WB_BYPASS_EN
            if (w_wbWrite && (bus.wb_rd_idx == w_rs2Idx)) begin
                w_rs2Data = bus.wb_data;
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && w_wbWrite) begin
            r_regFile[bus.wb_rd_idx] <= bus.wb_data;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < 32; i++) begin
            if (rst) begin
                r_sb[i] <= '0;
            end else begin
                r_sb[i] <= w_sbNext[i];
            end
        end
    end

    // Flush wins over accept (in_ready is low during flush); content is held under backpressure.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_outValid <= 1'b0;
            r_outPc    <= RESET_PC;
            r_outInstr <= 32'h0000_0013;
            r_outRs1   <= '0;
            r_outRs2   <= '0;
            r_outImm   <= '0;
            r_outRdIdx <= '0;
            r_outWben  <= 1'b0;
        end else if (bus.flush) begin
            r_outValid <= 1'b0;
        end else if (w_accept) begin
            r_outValid <= 1'b1;
            r_outPc    <= bus.in_pc;
            r_outInstr <= bus.in_instr;
            r_outRs1   <= w_rs1Data;
            r_outRs2   <= w_rs2Data;
            r_outImm   <= w_imm;
            r_outRdIdx <= w_writesRd ? w_rdIdx : 5'd0;
            r_outWben  <= w_writesRd & (w_rdIdx != 5'd0);
        end else if (w_issue) begin
            r_outValid <= 1'b0;
        end
    end

    assign bus.in_ready     = w_inReady;
    assign bus.out_valid    = r_outValid;
    assign bus.out_pc       = r_outPc;
    assign bus.out_instr    = r_outInstr;
    assign bus.out_rs1_data = r_outRs1;
    assign bus.out_rs2_data = r_outRs2;
    assign bus.out_imm      = r_outImm;
    assign bus.out_rd_idx   = r_outRdIdx;
    assign bus.out_wben     = r_outWben;
endmodule

// File: tb/tb_id_stage_sb.sv
// Self-checking bench for id_stage_sb: behavioural model compared every cycle plus directed literal checks.
// Follows ID_SB_WB_BYPASS_EN the same way the design does.
module tb_id_stage_sb;
    localparam int          XLEN     = 64;
    localparam int          SB_CNT_W = 2;
    localparam int          SB_MAX   = (1 << SB_CNT_W) - 1;
    localparam logic [63:0] RESET_PC = 64'h0000_0000_8000_0000;
`ifdef ID_SB_WB_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    id_stage_sb_if #(.XLEN(XLEN)) bus ();

    id_stage_sb #(.XLEN(XLEN), .SB_CNT_W(SB_CNT_W), .RESET_PC(RESET_PC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int errors = 0;
    int checks = 0;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model state: architectural registers, outstanding-writer counts and the expected output slice.
    longint unsigned mRegs [32];
    int              mSb [32];
    bit              mInit = 1'b0;
    bit              mValid;
    bit              mWben;
    logic [63:0]     mPc, mRs1, mRs2, mImm;
    logic [31:0]     mInstr;
    logic [4:0]      mRd;

    function automatic void decodeModel(input logic [31:0] ins, output bit r1, output bit r2,
                                        output bit wr, output logic [63:0] imm);
        longint s;
        longint u;
        s   = longint'($signed(ins));
        u   = longint'({32'b0, ins});
        r1  = 0; r2 = 0; wr = 0; imm = 0;
        case (ins[6:0])
            7'h37, 7'h17: begin wr = 1; imm = (s >>> 12) << 12; end
            7'h6F: begin
                wr  = 1;
                imm = ((s >>> 31) << 20) | (((u >> 12) & 255) << 12) | (((u >> 20) & 1) << 11)
                    | (((u >> 21) & 1023) << 1);
            end
            7'h67, 7'h03, 7'h13, 7'h1B: begin r1 = 1; wr = 1; imm = s >>> 20; end
            7'h63: begin
                r1  = 1; r2 = 1;
                imm = ((s >>> 31) << 12) | (((u >> 7) & 1) << 11) | (((u >> 25) & 63) << 5)
                    | (((u >> 8) & 15) << 1);
            end
            7'h23: begin r1 = 1; r2 = 1; imm = ((s >>> 25) << 5) | ((u >> 7) & 31); end
            7'h33, 7'h3B: begin r1 = 1; r2 = 1; wr = 1; end
            default: imm = 0;
        endcase
    endfunction

    function automatic int effModel(input int idx);
        int inc;
        int dec;
        inc = (mValid && bus.out_ready && mWben && (int'(mRd) == idx)) ? 1 : 0;
        dec = (BYPASS && bus.wb_done && (int'(bus.wb_rd_idx) == idx) && (mSb[idx] + inc > 0)) ? 1 : 0;
        return mSb[idx] + inc - dec;
    endfunction

    function automatic bit modelReady();
        bit r1, r2, wr, haz;
        logic [63:0] imm;
        int s1, s2, d;
        decodeModel(bus.in_instr, r1, r2, wr, imm);
        s1  = int'(bus.in_instr[19:15]);
        s2  = int'(bus.in_instr[24:20]);
        d   = int'(bus.in_instr[11:7]);
        haz = (r1 && s1 != 0 && effModel(s1) != 0) || (r2 && s2 != 0 && effModel(s2) != 0)
           || (wr && d != 0 && effModel(d) == SB_MAX);
        return !bus.flush && (!mValid || bus.out_ready) && !haz;
    endfunction

    function automatic logic [63:0] readModel(input int idx);
        if (idx == 0) return 64'd0;
        if (BYPASS && bus.wb_done && bus.wb_wren && int'(bus.wb_rd_idx) == idx) return bus.wb_data;
        return mRegs[idx];
    endfunction

    always @(posedge clk) begin : modelUpdate
        bit issue, acc, r1, r2, wr;
        logic [63:0] imm, d1, d2;
        int inc, dec;
        if (rst) begin
            mInit  = 1;
            mValid = 0; mPc = RESET_PC; mInstr = 32'h13;
            mRs1 = 0; mRs2 = 0; mImm = 0; mRd = 0; mWben = 0;
            for (int i = 0; i < 32; i++) mSb[i] = 0;
        end else if (mInit) begin
            issue = mValid && bus.out_ready;
            acc   = bus.in_valid && modelReady();
            decodeModel(bus.in_instr, r1, r2, wr, imm);
            d1 = r1 ? readModel(int'(bus.in_instr[19:15])) : 64'd0;
            d2 = r2 ? readModel(int'(bus.in_instr[24:20])) : 64'd0;
            for (int i = 1; i < 32; i++) begin
                inc = (issue && mWben && int'(mRd) == i) ? 1 : 0;
                dec = (bus.wb_done && int'(bus.wb_rd_idx) == i) ? 1 : 0;
                if (inc == 1 && dec == 0) mSb[i] = mSb[i] + 1;
                else if (dec == 1 && inc == 0 && mSb[i] > 0) mSb[i] = mSb[i] - 1;
            end
            if (bus.wb_done && bus.wb_wren && bus.wb_rd_idx != 0) mRegs[bus.wb_rd_idx] = bus.wb_data;
            if (bus.flush) mValid = 0;
            else if (acc) begin
                mValid = 1; mPc = bus.in_pc; mInstr = bus.in_instr;
                mRs1 = d1; mRs2 = d2; mImm = imm;
                mRd   = wr ? bus.in_instr[11:7] : 5'd0;
                mWben = wr && (bus.in_instr[11:7] != 0);
            end else if (issue) mValid = 0;
        end
    end

    always @(negedge clk) begin
        if (mInit) begin
            checkOutput("in_ready", 64'(bus.in_ready), 64'(modelReady()));
            checkOutput("out_valid", 64'(bus.out_valid), 64'(mValid));
            checkOutput("out_pc", bus.out_pc, mPc);
            checkOutput("out_instr", 64'(bus.out_instr), 64'(mInstr));
            checkOutput("out_rs1_data", bus.out_rs1_data, mRs1);
            checkOutput("out_rs2_data", bus.out_rs2_data, mRs2);
            checkOutput("out_imm", bus.out_imm, mImm);
            checkOutput("out_rd_idx", 64'(bus.out_rd_idx), 64'(mRd));
            checkOutput("out_wben", 64'(bus.out_wben), 64'(mWben));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input bit v, input logic [63:0] pc, input logic [31:0] ins);
        bus.in_valid = v;
        bus.in_pc    = pc;
        bus.in_instr = ins;
    endtask

    task automatic setWb(input bit done, input bit wren, input logic [4:0] idx, input logic [63:0] data);
        bus.wb_done   = done;
        bus.wb_wren   = wren;
        bus.wb_rd_idx = idx;
        bus.wb_data   = data;
    endtask

    task automatic sendInstr(input logic [63:0] pc, input logic [31:0] ins, input int maxCycles);
        bit got;
        got = 0;
        applyStimulus(1, pc, ins);
        for (int c = 0; c < maxCycles && !got; c++) begin
            @(negedge clk);
            got = bus.in_ready;
            tick();
        end
        bus.in_valid = 0;
        checks++;
        if (!got) begin
            errors++;
            $display("[TB] FAIL accept_timeout: instr %h not accepted within %0d cycles", ins, maxCycles);
        end
    endtask

    localparam logic [31:0] ADDI_X1_5  = 32'h0050_0093;
    localparam logic [31:0] ADD_X2_X1  = 32'h0010_8133;
    localparam logic [31:0] ADDI_X6_7  = 32'h0070_0313;
    localparam logic [31:0] ADD_X8_X6  = 32'h0003_0433;
    localparam logic [31:0] LUI_X3     = 32'h1234_51B7;
    localparam logic [31:0] ADDI_X4_9  = 32'h0090_0213;
    localparam logic [31:0] ADD_X9_X4  = 32'h0002_04B3;
    localparam logic [31:0] LUI_X0     = 32'h1234_5037;
    localparam logic [31:0] SW_X5_8    = 32'h0050_2423;
    localparam logic [31:0] JAL_NEG    = 32'h801F_F06F;

    initial begin
        bit gotNow;
        applyStimulus(0, 64'd0, 32'h13);
        bus.out_ready = 0;
        bus.flush     = 0;
        setWb(0, 0, 0, 0);
        rst = 1;
        tick(); tick();
        checkOutput("rst_out_valid", 64'(bus.out_valid), 64'd0);
        checkOutput("rst_out_pc", bus.out_pc, RESET_PC);
        checkOutput("rst_out_instr", 64'(bus.out_instr), 64'h13);
        checkOutput("rst_in_ready", 64'(bus.in_ready), 64'd1);
        rst = 0;

        // Give every register a known value; counters are idle so these retirements must not wrap.
        for (int i = 1; i < 32; i++) begin
            setWb(1, 1, 5'(i), 64'h1000 + 64'(i));
            tick();
        end
        setWb(0, 0, 0, 0);

        sendInstr(64'h100, ADDI_X1_5, 4);
        checkOutput("addi_valid", 64'(bus.out_valid), 64'd1);
        checkOutput("addi_imm", bus.out_imm, 64'd5);
        checkOutput("addi_rd", 64'(bus.out_rd_idx), 64'd1);
        checkOutput("addi_wben", 64'(bus.out_wben), 64'd1);
        checkOutput("addi_rs1", bus.out_rs1_data, 64'd0);

        bus.out_ready = 1;
        tick();
        applyStimulus(1, 64'h104, ADD_X2_X1);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            checkOutput("raw_stall", 64'(bus.in_ready), 64'd0);
            tick();
        end
        setWb(1, 1, 5'd1, 64'h55);
        @(negedge clk);
        gotNow = bus.in_ready;
        checkOutput("raw_wb_cycle_ready", 64'(gotNow), 64'(BYPASS));
        tick();
        setWb(0, 0, 0, 0);
        if (!gotNow) sendInstr(64'h104, ADD_X2_X1, 3);
        else bus.in_valid = 0;
        checkOutput("raw_rs1", bus.out_rs1_data, 64'h55);
        checkOutput("raw_rs2", bus.out_rs2_data, 64'h55);
        tick();

        bus.out_ready = 0;
        sendInstr(64'h200, ADDI_X6_7, 4);
        applyStimulus(1, 64'h204, ADD_X8_X6);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checkOutput("bp_in_ready", 64'(bus.in_ready), 64'd0);
            checkOutput("bp_instr", 64'(bus.out_instr), 64'(ADDI_X6_7));
            checkOutput("bp_imm", bus.out_imm, 64'd7);
            checkOutput("bp_pc", bus.out_pc, 64'h200);
            tick();
        end
        bus.out_ready = 1;
        tick();
        @(negedge clk);
        checkOutput("bp_sb_after_issue", 64'(bus.in_ready), 64'd0);
        tick();
        setWb(1, 1, 5'd6, 64'h66);
        tick();
        setWb(0, 0, 0, 0);
        sendInstr(64'h204, ADD_X8_X6, 3);
        checkOutput("bp_reader_rs1", bus.out_rs1_data, 64'h66);
        tick();

        for (int k = 0; k < 3; k++) sendInstr(64'h300 + 64'(4 * k), LUI_X3, 4);
        applyStimulus(1, 64'h30C, LUI_X3);
        tick(); tick();
        @(negedge clk);
        checkOutput("waw_stall", 64'(bus.in_ready), 64'd0);
        checkOutput("waw_imm", bus.out_imm, 64'h1234_5000);
        checkOutput("waw_rd", 64'(bus.out_rd_idx), 64'd3);
        tick();
        setWb(1, 1, 5'd3, 64'h33);
        @(negedge clk);
        gotNow = bus.in_ready;
        checkOutput("waw_wb_cycle_ready", 64'(gotNow), 64'(BYPASS));
        tick();
        setWb(0, 0, 0, 0);
        if (!gotNow) sendInstr(64'h30C, LUI_X3, 3);
        else bus.in_valid = 0;
        checkOutput("waw_fourth_pc", bus.out_pc, 64'h30C);
        tick();
        for (int k = 0; k < 3; k++) begin
            setWb(1, 0, 5'd3, 64'h0);
            tick();
        end
        setWb(0, 0, 0, 0);

        bus.out_ready = 0;
        sendInstr(64'h400, ADDI_X4_9, 4);
        bus.flush = 1;
        tick();
        bus.flush = 0;
        checkOutput("flush_valid", 64'(bus.out_valid), 64'd0);
        applyStimulus(0, 64'h404, ADD_X9_X4);
        @(negedge clk);
        checkOutput("flush_no_sb", 64'(bus.in_ready), 64'd1);
        tick();
        sendInstr(64'h408, ADDI_X4_9, 4);
        bus.out_ready = 1;
        bus.flush     = 1;
        tick();
        bus.flush     = 0;
        bus.out_ready = 0;
        checkOutput("flush_issue_valid", 64'(bus.out_valid), 64'd0);
        applyStimulus(0, 64'h40C, ADD_X9_X4);
        @(negedge clk);
        checkOutput("flush_issue_sb", 64'(bus.in_ready), 64'd0);
        tick();
        setWb(1, 0, 5'd4, 64'hDEAD);
        tick();
        setWb(0, 0, 0, 0);
        sendInstr(64'h40C, ADD_X9_X4, 3);
        checkOutput("killed_x4_unchanged", bus.out_rs1_data, 64'h1004);
        bus.out_ready = 1;
        tick();

        sendInstr(64'h500, LUI_X0, 2);
        checkOutput("lui_x0_wben", 64'(bus.out_wben), 64'd0);
        checkOutput("lui_x0_imm", bus.out_imm, 64'h1234_5000);
        sendInstr(64'h504, SW_X5_8, 2);
        checkOutput("sw_rs1", bus.out_rs1_data, 64'd0);
        checkOutput("sw_rs2", bus.out_rs2_data, 64'h1005);
        checkOutput("sw_imm", bus.out_imm, 64'd8);
        checkOutput("sw_wben", 64'(bus.out_wben), 64'd0);
        sendInstr(64'h508, JAL_NEG, 2);
        checkOutput("jal_imm", bus.out_imm, 64'hFFFF_FFFF_FFFF_F800);
        checkOutput("jal_wben", 64'(bus.out_wben), 64'd0);
        tick(); tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/id_stage_sb.md
Name: id_stage_sb

Overview:
- Parametrised, handshaked successor to the combinational decode stage.
- Decodes RV64I register usage and immediates, then reads an internal register file.
- Tracks in-flight writers with a per-register scoreboard and stalls on RAW hazards.
- Presents one decoded instruction at a time through a registered valid/ready output slice to the execute stage.
- Sits between IF (upstream valid/ready) and EX; WB reports completions back.

Parameters:
- XLEN, 64, datapath and register width.
- SB_CNT_W, 2, width of each per-register scoreboard counter; max outstanding writers per register = 2^SB_CNT_W-1.
- RESET_PC, 0, value of out_pc after reset.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  IF presents instruction
- in_ready  out  1  stage accepts this cycle
- in_pc  in  XLEN  instruction pc
- in_instr  in  32  instruction word
- out_valid  out  1  decoded instruction valid
- out_ready  in  1  EX accepts
- out_pc  out  XLEN  registered pc
- out_instr  out  32  registered instruction
- out_rs1_data  out  XLEN  rs1 operand
- out_rs2_data  out  XLEN  rs2 operand
- out_imm  out  XLEN  sign-extended immediate
- out_rd_idx  out  5  destination index
- out_wben  out  1  instruction writes rd (0 when rd==x0)
- wb_done  in  1  one issued writer retires; decrement scoreboard[wb_rd_idx]
- wb_wren  in  1  write wb_data into wb_rd_idx (only meaningful with wb_done)
- wb_rd_idx  in  5  retiring destination
- wb_data  in  XLEN  write data
- flush  in  1  discard output slice content

Behaviour:
- Reset (sync, rst=1): out_valid=0, out_pc=RESET_PC, out_instr=0x00000013 (NOP), out_* data/imm/rd=0, out_wben=0, all scoreboard counters=0. Regfile contents are not reset; x0 always reads 0.
- Decode by opcode[6:0]:
  - uses_rs1: JALR, BRANCH, LOAD, STORE, OP-IMM(-32), OP(-32).
  - uses_rs2: BRANCH, STORE, OP(-32).
  - writes_rd: LUI, AUIPC, JAL, JALR, LOAD, OP-IMM(-32), OP(-32).
  - imm formats: I/S/B/U/J, sign-extended to XLEN; imm=0 otherwise.
  - Unknown opcode: no reads, no write, imm=0; still passed through.
- Issue: issue = out_valid & out_ready.
- Scoreboard update per cycle:
  - inc = issue & out_wben at out_rd_idx.
  - dec = wb_done at wb_rd_idx.
  - Same index both: net 0.
  - wb_done on a counter at 0: counter stays 0 (error, no wrap).
  - x0 counter is never incremented.
- Hazard for source s (uses_s, idx≠0):
  - eff = sb[idx] + (issue&out_wben&out_rd_idx==idx) − (bypass-qualified dec, see Optional Feature).
  - Hazard when eff≠0.
- WAW limit: writes_rd with rd≠0 and eff(rd)==2^SB_CNT_W−1 → stall.
- in_ready = ~flush & (~out_valid | out_ready) & ~hazard.
- Accept = in_valid & in_ready. On accept, next cycle: out_valid=1, all out_* loaded (operands read at accept). Latency: 1 cycle in→out.
- If ~accept & issue: out_valid←0. Otherwise out_* hold while out_valid & ~out_ready (stable under backpressure).
- flush: out_valid←0 next cycle, nothing accepted that cycle. The scoreboard is untouched, except an issue coinciding with flush still increments (the issued instruction belongs to EX). EX must still report wb_done for killed writers, with wb_wren=0.
- Regfile write on wb_done & wb_wren & wb_rd_idx≠0, at the clock edge.
- rst mid-operation overrides flush, handshakes and writes.

Optional Feature:
- Macro ID_SB_WB_BYPASS_EN.
- Defined:
  - A source matching wb_rd_idx with wb_done & wb_wren reads wb_data in the same cycle.
  - That wb_done counts in eff, so a register whose counter drops 1→0 this cycle is not a hazard.
- Undefined:
  - Read returns the pre-write value.
  - The wb_done is excluded from eff, so the stage stalls one extra cycle and reads the written value the next cycle.

Test Plan:
- Reset → out_valid=0, out_pc=RESET_PC, in_ready=1; ADDI x1,x0,5 accepted → next cycle out_valid=1, out_imm=5, out_rd_idx=1, out_wben=1, out_rs1_data=0.
- Issue ADDI x1; then present ADD x2,x1,x1 → in_ready=0 until wb_done/wren x1=0x55:
  - with macro: accepted that cycle, rs1=rs2=0x55.
  - without macro: accepted next cycle, rs1=rs2=0x55.
- out_ready=0 for 4 cycles with out_valid=1 → all out_* unchanged, in_ready=0; release → issue, scoreboard[rd] becomes 1.
- SB_CNT_W=2: issue three LUI x3 without wb → fourth LUI x3 stalls; one wb_done x3 → accepted.
- flush while out_valid=1, out_ready=0 → out_valid=0 next cycle, no scoreboard change; wb_done with wb_wren=0 on an issued-then-killed x4 → counter 0, regfile x4 unchanged.
- LUI x0 and SW x5 (rs1=x0) → out_wben=0, x0 reads 0, never stalls; JAL imm −2048 → out_imm=0xFFFF_FFFF_FFFF_F800.
